// File: rtl/register_file_mp_pkg.sv
// Shared defaults for the GPR store: geometry and the hard-wired zero register.
// Decode and the hazard unit import the same values so that address widths agree.
package register_file_mp_pkg;

  localparam int RF_W         = 32;
  localparam int RF_DEPTH     = 32;
  localparam int RF_AW        = $clog2(RF_DEPTH);
  localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// Per-register busy scoreboard: an issue marks the destination busy, a writeback clears it,
// and an issue wins over a writeback when both hit the same register in one cycle.
module register_file_mp_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NW       = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic               issue_en,
  input  logic [AW-1:0]      issue_addr,
  output logic [DEPTH-1:0]   busy,
  output logic               busy_any
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic             issue_ok;

  function automatic logic [DEPTH-1:0] onehot(input logic [AW-1:0] a);
    onehot = {{(DEPTH-1){1'b0}}, 1'b1} << a;
  endfunction

  // Issues to the hard-wired zero register never create a producer.
  assign issue_ok = issue_en &&
                    !((ZERO_REG != 0) && (issue_addr == AW'(RF_ZERO_ADDR)));

  // Build the set and clear masks for this cycle.
  always_comb begin
    set_vec = issue_ok ? onehot(issue_addr) : {DEPTH{1'b0}};
    clr_vec = {DEPTH{1'b0}};
    for (int p = 0; p < NW; p++) begin
      clr_vec = clr_vec | (wr_en[p] ? onehot(wr_addr[p*AW +: AW]) : {DEPTH{1'b0}});
    end
  end

  // Busy vector: set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= {DEPTH{1'b0}};
    end else begin
      busy <= set_vec | (busy & ~clr_vec);
    end
  end

  assign busy_any = |busy;

endmodule

// File: rtl/register_file_mp.sv
// Multi-ported GPR store with same-cycle write-to-read forwarding and a busy scoreboard.
// Reads are combinational; writes commit on the rising edge, highest port index winning.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter  int W        = RF_W,
  parameter  int DEPTH    = RF_DEPTH,
  parameter  int NR       = 2,
  parameter  int NW       = 1,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NW-1:0]      wr_en,
  input  logic [NW*AW-1:0]   wr_addr,
  input  logic [NW*W-1:0]    wr_data,
  input  logic [NR*AW-1:0]   rd_addr,
  output logic [NR*W-1:0]    rd_data,
  output logic [NR-1:0]      rd_busy,
  input  logic               issue_en,
  input  logic [AW-1:0]      issue_addr,
  output logic               busy_any
);

  logic [W-1:0]     mem [DEPTH];
  logic [NW-1:0]    wr_ok;
  logic [DEPTH-1:0] busy;

  for (genvar p = 0; p < NW; p++) begin : g_wr
    assign wr_ok[p] = wr_en[p] &&
                      !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == AW'(RF_ZERO_ADDR)));
  end

  // Storage: ports are visited in ascending order so the highest index lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {W{1'b0}};
      end
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (wr_ok[p]) begin
          mem[wr_addr[p*AW +: AW]] <= wr_data[p*W +: W];
        end
      end
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    logic [AW-1:0] addr;
    logic          is_zero;
    logic          hit;
    logic [W-1:0]  fwd;

    assign addr    = rd_addr[r*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == AW'(RF_ZERO_ADDR));

    // Forwarding select: the highest-index matching writer overrides lower ones.
    always_comb begin
      hit = 1'b0;
      fwd = {W{1'b0}};
      for (int p = 0; p < NW; p++) begin
        hit = hit | (wr_en[p] && (wr_addr[p*AW +: AW] == addr));
        fwd = (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) ? wr_data[p*W +: W] : fwd;
      end
    end

    assign rd_data[r*W +: W] = is_zero                     ? {W{1'b0}} :
                               ((BYPASS != 0) && hit)      ? fwd       :
                                                             mem[addr];
    assign rd_busy[r]        = busy[addr] & ~((BYPASS != 0) && hit);
  end

  register_file_mp_scoreboard #(
    .DEPTH    (DEPTH),
    .NW       (NW),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy       (busy),
    .busy_any   (busy_any)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a forwarding and a non-forwarding instance share one stimulus
// stream and are compared every cycle against an array-based model of the register file.
module tb_register_file_mp;

  localparam int W     = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*W-1:0]   wr_data;
  logic [NR*AW-1:0]  rd_addr;
  logic              issue_en;
  logic [AW-1:0]     issue_addr;
  logic [NR*W-1:0]   rd_data_b, rd_data_n;
  logic [NR-1:0]     rd_busy_b, rd_busy_n;
  logic              busy_any_b, busy_any_n;

  register_file_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)) dut_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_any(busy_any_b));

  register_file_mp #(.W(W), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(0)) dut_nob (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_any(busy_any_n));

  // Reference state: register contents and outstanding-producer flags.
  logic [W-1:0] m_reg [DEPTH];
  bit           m_busy [DEPTH];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input int r, input bit byp);
    logic [AW-1:0] a;
    logic [W-1:0]  v;
    a = rd_addr[r*AW +: AW];
    v = m_reg[a];
    if (a == 0) return '0;
    if (byp)
      for (int p = 0; p < NW; p++)
        if (wr_en[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*W +: W];
    return v;
  endfunction

  function automatic bit exp_busy(input int r, input bit byp);
    logic [AW-1:0] a;
    bit            fwd;
    a   = rd_addr[r*AW +: AW];
    fwd = 1'b0;
    for (int p = 0; p < NW; p++)
      if (wr_en[p] && wr_addr[p*AW +: AW] == a) fwd = 1'b1;
    return m_busy[a] && !(byp && fwd);
  endfunction

  function automatic bit exp_any();
    bit any;
    any = 1'b0;
    for (int i = 0; i < DEPTH; i++) any |= m_busy[i];
    return any;
  endfunction

  task automatic model_clock();
    logic [AW-1:0] a;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NW; p++) begin
        if (wr_en[p]) begin
          a = wr_addr[p*AW +: AW];
          m_busy[a] = 1'b0;
          if (a != 0) m_reg[a] = wr_data[p*W +: W];
        end
      end
      if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int r = 0; r < NR; r++) begin
      chk($sformatf("rd_data_byp[%0d]", r), rd_data_b[r*W +: W], exp_rd(r, 1'b1));
      chk($sformatf("rd_data_nob[%0d]", r), rd_data_n[r*W +: W], exp_rd(r, 1'b0));
      chk($sformatf("rd_busy_byp[%0d]", r), W'(rd_busy_b[r]), W'(exp_busy(r, 1'b1)));
      chk($sformatf("rd_busy_nob[%0d]", r), W'(rd_busy_n[r]), W'(exp_busy(r, 1'b0)));
    end
    chk("busy_any_byp", W'(busy_any_b), W'(exp_any()));
    chk("busy_any_nob", W'(busy_any_n), W'(exp_any()));
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    check_all();
    tick();
  endtask

  task automatic idle();
    reset    = 1'b0;
    wr_en    = '0;
    issue_en = 1'b0;
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = a;
    wr_data[p*W +: W]    = d;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    rd_addr[r*AW +: AW] = a;
  endtask

  task automatic set_issue(input logic [AW-1:0] a);
    issue_en   = 1'b1;
    issue_addr = a;
  endtask

  initial begin
    reset = 1'b1; wr_en = '0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; issue_en = 1'b0; issue_addr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    @(negedge clk);
    tick();

    // Everything reads zero and nothing is busy after reset.
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(0, AW'(a));
      set_rd(1, AW'(DEPTH - 1 - a));
      settle();
      chk("t1_port0_zero", rd_data_b[0 +: W], 32'h0000_0000);
      chk("t1_port1_zero", rd_data_b[W +: W], 32'h0000_0000);
      chk("t1_busy_any", W'(busy_any_b), 32'h0000_0000);
      check_all();
      tick();
    end

    // Plain write then read one cycle later; writes to r0 are discarded.
    idle(); set_wr(0, 5'd5, 32'hDEAD_BEEF); set_rd(1, 5'd0);
    cycle();
    idle(); set_rd(1, 5'd5);
    settle();
    chk("t2_r5_byp", rd_data_b[W +: W], 32'hDEAD_BEEF);
    chk("t2_r5_nob", rd_data_n[W +: W], 32'hDEAD_BEEF);
    check_all(); tick();
    idle(); set_wr(0, 5'd0, 32'h0000_1234); set_rd(0, 5'd0);
    settle();
    chk("t2_r0_fwd", rd_data_b[0 +: W], 32'h0000_0000);
    check_all(); tick();
    idle(); set_rd(0, 5'd0);
    settle();
    chk("t2_r0_after", rd_data_b[0 +: W], 32'h0000_0000);
    check_all(); tick();

    // Same-cycle forwarding versus the stored value.
    idle(); set_wr(0, 5'd7, 32'hA5A5_A5A5); set_rd(0, 5'd7);
    settle();
    chk("t3_fwd_byp", rd_data_b[0 +: W], 32'hA5A5_A5A5);
    chk("t3_old_nob", rd_data_n[0 +: W], 32'h0000_0000);
    check_all(); tick();
    idle(); set_rd(0, 5'd7);
    settle();
    chk("t3_r7_nob", rd_data_n[0 +: W], 32'hA5A5_A5A5);
    check_all(); tick();

    // Two ports writing one register: port 1 wins, also when forwarded.
    idle(); set_wr(0, 5'd9, 32'h0000_0011); set_wr(1, 5'd9, 32'h0000_0022); set_rd(0, 5'd9);
    settle();
    chk("t4_fwd_prio", rd_data_b[0 +: W], 32'h0000_0022);
    check_all(); tick();
    idle(); set_rd(0, 5'd9);
    settle();
    chk("t4_r9", rd_data_n[0 +: W], 32'h0000_0022);
    check_all(); tick();

    // Scoreboard: issue, forwarded writeback, clear, and issue racing writeback.
    idle(); set_issue(5'd3); set_rd(0, 5'd3);
    cycle();
    idle(); set_rd(0, 5'd3);
    settle();
    chk("t5_busy", W'(rd_busy_b[0]), 32'h0000_0001);
    chk("t5_busy_any", W'(busy_any_b), 32'h0000_0001);
    check_all(); tick();
    idle(); set_wr(0, 5'd3, 32'h0000_0077); set_rd(0, 5'd3);
    settle();
    chk("t5_wb_fwd_busy", W'(rd_busy_b[0]), 32'h0000_0000);
    chk("t5_wb_nob_busy", W'(rd_busy_n[0]), 32'h0000_0001);
    check_all(); tick();
    idle(); set_rd(0, 5'd3);
    settle();
    chk("t5_cleared", W'(rd_busy_n[0]), 32'h0000_0000);
    chk("t5_any_clear", W'(busy_any_n), 32'h0000_0000);
    check_all(); tick();
    idle(); set_issue(5'd3); set_wr(1, 5'd3, 32'h0000_0088);
    cycle();
    idle(); set_rd(0, 5'd3);
    settle();
    chk("t5_issue_wins", W'(rd_busy_n[0]), 32'h0000_0001);
    check_all(); tick();
    idle(); set_wr(0, 5'd3, 32'h0000_0099);
    cycle();

    // Reset drops same-cycle writes and clears the scoreboard.
    idle(); set_issue(5'd4);
    cycle();
    idle(); set_wr(0, 5'd4, 32'h0000_0055);
    cycle();
    idle(); set_issue(5'd4);
    cycle();
    idle(); reset = 1'b1; set_wr(0, 5'd6, 32'h0000_0066);
    cycle();
    idle(); set_rd(0, 5'd4); set_rd(1, 5'd6);
    settle();
    chk("t6_r4", rd_data_n[0 +: W], 32'h0000_0000);
    chk("t6_r6", rd_data_n[W +: W], 32'h0000_0000);
    chk("t6_busy_any", W'(busy_any_n), 32'h0000_0000);
    check_all(); tick();

    // Random traffic concentrated on a few registers to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      reset = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < NW; p++) begin
        if ($urandom_range(0, 1) == 1)
          set_wr(p, AW'($urandom_range(0, ($urandom_range(0, 3) == 0) ? DEPTH - 1 : 7)), $urandom);
      end
      for (int r = 0; r < NR; r++) set_rd(r, AW'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) set_issue(AW'($urandom_range(0, 7)));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
